// File: rtl/bp_wb_pkg.sv
// Shared types and sizing helpers for the multi-line BP writeback block.
// Imported by the controller top and its write FIFO.
package bp_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

    // Index width for n entries (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value n itself.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    // Issue must stop while enough room remains for every read in flight.
    function automatic int unsigned prog_full_thr(
        input int unsigned depth,
        input int unsigned lat
    );
        return depth - lat - 1;
    endfunction

endpackage

// File: rtl/bp_wb_fifo.sv
// Show-ahead write FIFO with occupancy count and programmable-full flag.
// Head data is valid whenever the FIFO is not empty.
module bp_wb_fifo
    import bp_wb_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int DEPTH  = 16,
    parameter int PF_THR = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_data,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_empty,
    output logic [cnt_w(DEPTH)-1:0]   o_count,
    output logic                      o_prog_full
);

    localparam int AW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] PF = CW'(PF_THR);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop       = i_pop && (r_count != '0);
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_prog_full = (r_count >= PF);
    assign o_data      = o_empty ? '0 : r_mem[r_rd];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_multiline_writeback.sv
// Streams line_num x Line_width words from the BP bank array into a DDR
// write FIFO, rotating through MAC groups from a chosen start group.
module bp_multiline_writeback
    import bp_wb_pkg::*;
#(
    parameter int X_MAC            = 4,
    parameter int X_MESH           = 16,
    parameter int ADDR_LEN         = 16,
    parameter int DATA_LEN         = 16,
    parameter int C_AXI_DATA_WIDTH = DATA_LEN * X_MESH,
    parameter int DDR_ADDR_LEN     = 32,
    parameter int SINGLE_LEN       = 24,
    parameter int LINE_W           = 8,
    parameter int BP_RD_LAT        = 2,
    parameter int FIFO_DEPTH       = 16,
    parameter int BUFFER_NUM       = X_MAC * X_MESH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             conf,
    input  logic                             abort,
    input  logic [DDR_ADDR_LEN-1:0]          ddr_st_addr,
    input  logic [SINGLE_LEN-1:0]            data_ddr_byte,
    input  logic [ADDR_LEN-1:0]              BP_st_addr,
    input  logic [$clog2(X_MAC)-1:0]         BP_st_num,
    input  logic [LINE_W-1:0]                line_num,
    input  logic [SINGLE_LEN-1:0]            Line_width,
    input  logic                             axi_ug_idle,
    output logic [DDR_ADDR_LEN-1:0]          ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]            ddr_len,
    output logic                             ddr_conf,
    input  logic                             ddr_write_req,
    output logic                             ddr_write_empty,
    output logic [C_AXI_DATA_WIDTH-1:0]      ddr_write_data_out,
    output logic [ADDR_LEN*BUFFER_NUM-1:0]   BP_addr_out,
    input  logic [DATA_LEN*BUFFER_NUM-1:0]   BP_data_in,
    output logic                             conf_err,
    output logic                             idle
);

    localparam int GW     = $clog2(X_MAC);
    localparam int DW     = cnt_w(BP_RD_LAT);
    localparam int CW     = cnt_w(FIFO_DEPTH);
    localparam int PF_THR = prog_full_thr(FIFO_DEPTH, BP_RD_LAT);

    wb_state_e                 r_state;
    wb_state_e                 w_next;
    logic [DDR_ADDR_LEN-1:0]   r_ddr_addr;
    logic [SINGLE_LEN-1:0]     r_ddr_len;
    logic                      r_ddr_conf;
    logic                      r_conf_err;
    logic [ADDR_LEN-1:0]       r_row;
    logic [SINGLE_LEN-1:0]     r_word;
    logic [SINGLE_LEN-1:0]     r_width;
    logic [GW-1:0]             r_group;
    logic [LINE_W-1:0]         r_lines;
    logic [DW-1:0]             r_drain;
    logic [BP_RD_LAT-1:0]      r_pv;
    logic [GW-1:0]             r_pg [BP_RD_LAT];

    logic                      w_accept;
    logic                      w_issue;
    logic                      w_line_end;
    logic                      w_last;
    logic [ADDR_LEN-1:0]       w_addr;
    logic                      w_push;
    logic [GW-1:0]             w_pg_out;
    logic [C_AXI_DATA_WIDTH-1:0] w_din;
    logic                      w_empty;
    logic                      w_prog_full;
    logic [CW-1:0]             w_count;
    logic [DATA_LEN-1:0]       w_bank [X_MAC][X_MESH];

    assign w_accept   = conf && !abort && (r_state == IDLE)
                        && (line_num != '0) && (Line_width != '0);
    assign w_issue    = (r_state == ISSUE) && !w_prog_full && !abort;
    assign w_line_end = (r_word == r_width - 1'b1);
    assign w_last     = w_issue && w_line_end && (r_lines == LINE_W'(1));
    assign w_addr     = r_row + ADDR_LEN'(r_word);
    assign w_pg_out   = r_pg[BP_RD_LAT-1];
    assign w_push     = r_pv[BP_RD_LAT-1] && !abort;

    assign BP_addr_out     = {BUFFER_NUM{w_addr}};
    assign ddr_st_addr_out = r_ddr_addr;
    assign ddr_len         = r_ddr_len;
    assign ddr_conf        = r_ddr_conf;
    assign conf_err        = r_conf_err;
    assign ddr_write_empty = w_empty;
    assign idle            = (r_state == IDLE) && w_empty && axi_ug_idle;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: abort wins everywhere, drain waits out the read pipeline.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (w_accept) w_next = ISSUE;
                ISSUE:   if (w_last) w_next = DRAIN;
                DRAIN:   if (r_drain == DW'(BP_RD_LAT - 1)) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Drain timer counts cycles spent in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain <= '0;
        end else if (r_state == DRAIN) begin
            r_drain <= r_drain + 1'b1;
        end else begin
            r_drain <= '0;
        end
    end

    // Job acceptance: latch DDR job, pulse ddr_conf or conf_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ddr_addr <= '0;
            r_ddr_len  <= '0;
            r_ddr_conf <= 1'b0;
            r_conf_err <= 1'b0;
        end else begin
            r_ddr_conf <= w_accept;
            r_conf_err <= conf && !abort && !w_accept;
            if (w_accept) begin
                r_ddr_addr <= ddr_st_addr;
                r_ddr_len  <= data_ddr_byte;
            end
        end
    end

    // Address sequencer: walk words, rotate groups, bump row on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row   <= '0;
            r_word  <= '0;
            r_width <= '0;
            r_group <= '0;
            r_lines <= '0;
        end else if (w_accept) begin
            r_row   <= BP_st_addr;
            r_word  <= '0;
            r_width <= Line_width;
            r_group <= BP_st_num;
            r_lines <= line_num;
        end else if (w_issue) begin
            if (w_line_end) begin
                r_word  <= '0;
                r_group <= r_group + 1'b1;
                r_lines <= r_lines - 1'b1;
                if (r_group == GW'(X_MAC - 1)) begin
                    r_row <= r_row + ADDR_LEN'(r_width);
                end
            end else begin
                r_word <= r_word + 1'b1;
            end
        end
    end

    // Read pipeline tracks {valid, group} to align with buffer latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            for (int i = 0; i < BP_RD_LAT; i++) begin
                r_pg[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_pg[0] <= r_group;
            for (int i = 1; i < BP_RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pg[i] <= r_pg[i-1];
            end
            if (abort) begin
                r_pv <= '0;
            end
        end
    end

    for (genvar g = 0; g < X_MAC; g++) begin : g_grp
        for (genvar m = 0; m < X_MESH; m++) begin : g_mesh
            assign w_bank[g][m] =
                BP_data_in[(g + m*X_MAC)*DATA_LEN +: DATA_LEN];
        end
    end

    // Gather the returning group's mesh words into one FIFO word.
    always_comb begin
        w_din = '0;
        for (int m = 0; m < X_MESH; m++) begin
            w_din[m*DATA_LEN +: DATA_LEN] = w_bank[w_pg_out][m];
        end
    end

    bp_wb_fifo #(
        .WIDTH  (C_AXI_DATA_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .PF_THR (PF_THR)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (abort),
        .i_push      (w_push),
        .i_data      (w_din),
        .i_pop       (ddr_write_req),
        .o_data      (ddr_write_data_out),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_prog_full (w_prog_full)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && (w_count == CW'(FIFO_DEPTH)) && !ddr_write_req));

endmodule

// File: tb/tb_bp_multiline_writeback.sv
// Randomised bench for bp_multiline_writeback against a line/group model.
// Buffer banks are modelled as a latency line over the broadcast address.
module tb_bp_multiline_writeback;

    parameter int BP_RD_LAT = 2;

    localparam int XM  = 4;
    localparam int XS  = 16;
    localparam int AL  = 16;
    localparam int DL  = 16;
    localparam int AXW = DL * XS;
    localparam int BN  = XM * XS;

    logic              clk = 1'b0;
    logic              rst;
    logic              conf;
    logic              abort;
    logic [31:0]       ddr_st_addr;
    logic [23:0]       data_ddr_byte;
    logic [AL-1:0]     BP_st_addr;
    logic [1:0]        BP_st_num;
    logic [7:0]        line_num;
    logic [23:0]       Line_width;
    logic              axi_ug_idle;
    logic [31:0]       ddr_st_addr_out;
    logic [23:0]       ddr_len;
    logic              ddr_conf;
    logic              ddr_write_req = 1'b0;
    logic              ddr_write_empty;
    logic [AXW-1:0]    ddr_write_data_out;
    logic [AL*BN-1:0]  BP_addr_out;
    logic [DL*BN-1:0]  BP_data_in;
    logic              conf_err;
    logic              idle;

    always #5 clk = ~clk;

    bp_multiline_writeback #(.BP_RD_LAT(BP_RD_LAT)) dut (
        .clk                (clk),
        .rst                (rst),
        .conf               (conf),
        .abort              (abort),
        .ddr_st_addr        (ddr_st_addr),
        .data_ddr_byte      (data_ddr_byte),
        .BP_st_addr         (BP_st_addr),
        .BP_st_num          (BP_st_num),
        .line_num           (line_num),
        .Line_width         (Line_width),
        .axi_ug_idle        (axi_ug_idle),
        .ddr_st_addr_out    (ddr_st_addr_out),
        .ddr_len            (ddr_len),
        .ddr_conf           (ddr_conf),
        .ddr_write_req      (ddr_write_req),
        .ddr_write_empty    (ddr_write_empty),
        .ddr_write_data_out (ddr_write_data_out),
        .BP_addr_out        (BP_addr_out),
        .BP_data_in         (BP_data_in),
        .conf_err           (conf_err),
        .idle               (idle)
    );

    int n_tests = 0;
    int n_fail = 0;
    int n_pop = 0;
    int n_ddr_conf = 0;
    int pop_base = 0;
    int cf_base = 0;
    int req_mode = 2;
    bit chk_en = 1'b1;
    logic [31:0] last_da = '0;
    logic [AXW-1:0] exp_q [$];
    logic [AL*BN-1:0] hist [BP_RD_LAT];

    task automatic check(input string tag, input logic [AXW-1:0] got,
                         input logic [AXW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DL-1:0] bufval(input int g, input int m,
                                             input logic [AL-1:0] a);
        return DL'(int'(a) * 13 + g * 4099 + m * 257 + 'h5a3);
    endfunction

    // Bank model: each slice returns data for its own address, delayed.
    always @(posedge clk) begin
        for (int i = BP_RD_LAT - 1; i > 0; i--) begin
            hist[i] <= hist[i-1];
        end
        hist[0] <= BP_addr_out;
    end

    always_comb begin
        BP_data_in = '0;
        for (int g = 0; g < XM; g++) begin
            for (int m = 0; m < XS; m++) begin
                BP_data_in[(g + m*XM)*DL +: DL] =
                    bufval(g, m, hist[BP_RD_LAT-1][(g + m*XM)*AL +: AL]);
            end
        end
    end

    // Consumer: picks req for the coming edge and checks what it pops.
    always @(negedge clk) begin
        if (rst) begin
            ddr_write_req = 1'b0;
        end else begin
            case (req_mode)
                0:       ddr_write_req = 1'b0;
                1:       ddr_write_req = 1'b1;
                default: ddr_write_req = ($urandom_range(0, 3) != 0);
            endcase
            if (ddr_write_req && !ddr_write_empty) begin
                n_pop++;
                if (chk_en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected pop", AXW'(1), AXW'(0));
                    end else begin
                        check("fifo data", ddr_write_data_out,
                              exp_q.pop_front());
                    end
                end
            end
            if (ddr_conf) n_ddr_conf++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected stream: line l uses group (sn+l)%XM, row advances per wrap.
    task automatic build_exp(input logic [AL-1:0] sa, input int sn,
                             input int lines, input int width);
        int g;
        int row;
        logic [AL-1:0] a;
        logic [AXW-1:0] wd;
        for (int l = 0; l < lines; l++) begin
            g = (sn + l) % XM;
            row = int'(sa) + ((sn + l) / XM) * width;
            for (int w = 0; w < width; w++) begin
                a = AL'(row + w);
                for (int m = 0; m < XS; m++) begin
                    wd[m*DL +: DL] = bufval(g, m, a);
                end
                exp_q.push_back(wd);
            end
        end
    endtask

    task automatic start_job(input logic [AL-1:0] sa, input int sn,
                             input int lines, input int width,
                             input logic [31:0] da, input logic [23:0] nb);
        BP_st_addr = sa;
        BP_st_num = 2'(sn);
        line_num = 8'(lines);
        Line_width = 24'(width);
        ddr_st_addr = da;
        data_ddr_byte = nb;
        conf = 1'b1;
        cf_base = n_ddr_conf;
        pop_base = n_pop;
        last_da = da;
        build_exp(sa, sn, lines, width);
        tick(1);
        conf = 1'b0;
        check("ddr_conf pulse", AXW'(ddr_conf), AXW'(1));
        check("conf_err quiet", AXW'(conf_err), AXW'(0));
        check("ddr addr out", AXW'(ddr_st_addr_out), AXW'(da));
        check("ddr len", AXW'(ddr_len), AXW'(nb));
        tick(1);
        check("ddr_conf one cycle", AXW'(ddr_conf), AXW'(0));
    endtask

    task automatic wait_done(input string tag, input int words);
        int cyc = 0;
        while ((exp_q.size() != 0 || !idle) && cyc < 4000) begin
            tick(1);
            cyc++;
        end
        check({tag, " finished"}, AXW'(cyc < 4000), AXW'(1));
        check({tag, " words"}, AXW'(n_pop - pop_base), AXW'(words));
        check({tag, " ddr_conf count"}, AXW'(n_ddr_conf - cf_base),
              AXW'(1));
        check({tag, " empty"}, AXW'(ddr_write_empty), AXW'(1));
    endtask

    task automatic reject_conf(input string tag);
        int cf0;
        cf0 = n_ddr_conf;
        ddr_st_addr = 32'hdead_0000;
        conf = 1'b1;
        tick(1);
        conf = 1'b0;
        check({tag, " conf_err"}, AXW'(conf_err), AXW'(1));
        check({tag, " no ddr_conf"}, AXW'(ddr_conf), AXW'(0));
        check({tag, " addr held"}, AXW'(ddr_st_addr_out), AXW'(last_da));
        tick(1);
        check({tag, " conf_err 1 cycle"}, AXW'(conf_err), AXW'(0));
        check({tag, " ddr_conf count"}, AXW'(n_ddr_conf - cf0), AXW'(0));
    endtask

    int ln;
    int wd;
    int sn;
    logic [AL-1:0] sa;

    initial begin
        rst = 1'b1;
        conf = 1'b0;
        abort = 1'b0;
        axi_ug_idle = 1'b0;
        ddr_st_addr = '0;
        data_ddr_byte = '0;
        BP_st_addr = '0;
        BP_st_num = '0;
        line_num = '0;
        Line_width = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst empty", AXW'(ddr_write_empty), AXW'(1));
        check("rst ddr_conf", AXW'(ddr_conf), AXW'(0));
        check("rst conf_err", AXW'(conf_err), AXW'(0));
        check("rst idle", AXW'(idle), AXW'(0));
        check("rst ddr_len", AXW'(ddr_len), AXW'(0));
        check("rst ddr addr", AXW'(ddr_st_addr_out), AXW'(0));
        check("rst bp addr", AXW'(|BP_addr_out), AXW'(0));
        check("rst data", ddr_write_data_out, AXW'(0));
        rst = 1'b0;
        axi_ug_idle = 1'b1;
        tick(2);
        check("idle after reset", AXW'(idle), AXW'(1));

        req_mode = 2;
        start_job(16'h0010, 0, 2, 4, 32'h0000_1000, 24'd256);
        wait_done("jobA", 8);
        start_job(16'h0010, 3, 3, 2, 32'h0000_2000, 24'd192);
        wait_done("jobB", 6);

        req_mode = 0;
        start_job(16'h0200, 1, 5, 8, 32'h0000_3000, 24'd1280);
        tick(80);
        check("stall holds data", AXW'(ddr_write_empty), AXW'(0));
        check("stall no pops", AXW'(n_pop - pop_base), AXW'(0));
        check("stall not idle", AXW'(idle), AXW'(0));
        req_mode = 1;
        wait_done("stall", 40);
        axi_ug_idle = 1'b0;
        #1;
        check("idle needs axi", AXW'(idle), AXW'(0));
        axi_ug_idle = 1'b1;
        #1;

        req_mode = 2;
        line_num = 8'd0;
        Line_width = 24'd4;
        reject_conf("line0");
        line_num = 8'd3;
        Line_width = 24'd0;
        reject_conf("width0");
        check("idle after reject", AXW'(idle), AXW'(1));

        start_job(16'h0040, 2, 4, 8, 32'h0000_4000, 24'd1024);
        tick(3);
        reject_conf("busy");
        wait_done("busy job", 32);

        req_mode = 1;
        start_job(16'h0080, 0, 4, 8, 32'h0000_5000, 24'd1024);
        tick(9);
        chk_en = 1'b0;
        abort = 1'b1;
        conf = 1'b1;
        tick(1);
        abort = 1'b0;
        conf = 1'b0;
        exp_q.delete();
        check("abort empty", AXW'(ddr_write_empty), AXW'(1));
        check("abort idle", AXW'(idle), AXW'(1));
        check("abort beats conf", AXW'(ddr_conf | conf_err), AXW'(0));
        tick(BP_RD_LAT + 3);
        check("abort no late push", AXW'(ddr_write_empty), AXW'(1));
        chk_en = 1'b1;
        start_job(16'h0090, 1, 2, 5, 32'h0000_6000, 24'd320);
        wait_done("after abort", 10);

        req_mode = 2;
        start_job(16'hfffc, 3, 3, 5, 32'h0000_7000, 24'd480);
        wait_done("addr wrap", 15);

        for (int k = 0; k < 6; k++) begin
            ln = $urandom_range(1, 6);
            wd = $urandom_range(1, 12);
            sn = $urandom_range(0, 3);
            sa = AL'($urandom);
            start_job(sa, sn, ln, wd, $urandom, 24'($urandom));
            wait_done("rand job", ln * wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
